// File: rtl/vga_draw_pkg.sv
// Shared constants, types and octant helper for the framebuffer drawing sequencer.
package vga_draw_pkg;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;
    localparam int CRD_W = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        INIT  = 3'd2,
        OCT   = 3'd3,
        UPD   = 3'd4,
        DONE  = 3'd5
    } draw_state_e;

    typedef logic signed [CRD_W-1:0] crd_t;

    typedef struct packed {
        logic vis;
        crd_t px;
        crd_t py;
    } oct_pix_t;

    // Reflect the (ox, oy) offset into octant k around the centre and flag on-screen points.
    function automatic oct_pix_t oct_point(input logic [2:0] k,
                                           input crd_t cx, input crd_t cy,
                                           input crd_t ox, input crd_t oy,
                                           input crd_t sw, input crd_t sh);
        crd_t     dx;
        crd_t     dy;
        oct_pix_t p;
        case (k)
            3'd0:    begin dx =  ox; dy =  oy; end
            3'd1:    begin dx =  oy; dy =  ox; end
            3'd2:    begin dx = -ox; dy =  oy; end
            3'd3:    begin dx = -oy; dy =  ox; end
            3'd4:    begin dx = -ox; dy = -oy; end
            3'd5:    begin dx = -oy; dy = -ox; end
            3'd6:    begin dx =  ox; dy = -oy; end
            3'd7:    begin dx =  oy; dy = -ox; end
            default: begin dx =  ox; dy =  oy; end
        endcase
        p.px = cx + dx;
        p.py = cy + dy;
        if ((p.px >= 10'sd0) && (p.px < sw) && (p.py >= 10'sd0) && (p.py < sh)) begin
            p.vis = 1'b1;
        end else begin
            p.vis = 1'b0;
        end
        return p;
    endfunction

endpackage

// File: rtl/screen_clear_counter.sv
// Raster x/y counter for the clear pass: x runs fastest, wraps at the screen edge, flags the last pixel.
module screen_clear_counter
    import vga_draw_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clr,
    input  logic           en,
    output logic [X_W-1:0] cnt_x,
    output logic [Y_W-1:0] cnt_y,
    output logic [X_W-1:0] nxt_x,
    output logic [Y_W-1:0] nxt_y,
    output logic           last
);

    logic [X_W-1:0] cnt_x_r;
    logic [Y_W-1:0] cnt_y_r;
    logic [X_W-1:0] nxt_x_s;
    logic [Y_W-1:0] nxt_y_s;
    logic           last_s;

    // Next raster position and end-of-frame detection.
    always_comb begin
        last_s = (cnt_x_r == X_W'(SCREEN_W - 1)) && (cnt_y_r == Y_W'(SCREEN_H - 1));
        if (cnt_x_r == X_W'(SCREEN_W - 1)) begin
            nxt_x_s = {X_W{1'b0}};
            if (cnt_y_r == Y_W'(SCREEN_H - 1)) begin
                nxt_y_s = {Y_W{1'b0}};
            end else begin
                nxt_y_s = cnt_y_r + 7'd1;
            end
        end else begin
            nxt_x_s = cnt_x_r + 8'd1;
            nxt_y_s = cnt_y_r;
        end
    end

    // Counter register: cleared outside the clear pass, advances while enabled.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt_x_r <= {X_W{1'b0}};
            cnt_y_r <= {Y_W{1'b0}};
        end else if (en) begin
            cnt_x_r <= nxt_x_s;
            cnt_y_r <= nxt_y_s;
        end else begin
            cnt_x_r <= cnt_x_r;
            cnt_y_r <= cnt_y_r;
        end
    end

    assign cnt_x = cnt_x_r;
    assign cnt_y = cnt_y_r;
    assign nxt_x = nxt_x_s;
    assign nxt_y = nxt_y_s;
    assign last  = last_s;

endmodule

// File: rtl/circle_draw_ctrl.sv
// Clear-then-draw sequencer: wipes the framebuffer, then rasterises one midpoint circle.
module circle_draw_ctrl
    import vga_draw_pkg::*;
#(
    parameter int               SCREEN_W     = 160,
    parameter int               SCREEN_H     = 120,
    parameter logic [COL_W-1:0] CLEAR_COLOUR = 3'b000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [X_W-1:0]   centre_x,
    input  logic [Y_W-1:0]   centre_y,
    input  logic [6:0]       radius,
    input  logic [COL_W-1:0] colour,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour_out,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    localparam crd_t SW_C = crd_t'(SCREEN_W);
    localparam crd_t SH_C = crd_t'(SCREEN_H);

    draw_state_e      state_r;
    logic [2:0]       k_r;
    logic [X_W-1:0]   cx_r;
    logic [Y_W-1:0]   cy_r;
    logic [6:0]       rad_r;
    logic [COL_W-1:0] col_r;
    crd_t             ox_r;
    crd_t             oy_r;
    crd_t             crit_r;

    logic [X_W-1:0]   x_r;
    logic [Y_W-1:0]   y_r;
    logic [COL_W-1:0] col_out_r;
    logic             plot_r;
    logic             busy_r;
    logic             done_r;

    logic [X_W-1:0]   clr_x_s;
    logic [Y_W-1:0]   clr_y_s;
    logic [X_W-1:0]   clr_nx_s;
    logic [Y_W-1:0]   clr_ny_s;
    logic             clr_last_s;

    crd_t             rad_ext_s;
    crd_t             ox_n_s;
    crd_t             oy_n_s;
    crd_t             crit_n_s;
    logic             cont_s;
    logic [2:0]       sel_k_s;
    crd_t             sel_ox_s;
    crd_t             sel_oy_s;
    oct_pix_t         pix_s;

    screen_clear_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clear_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (state_r == IDLE),
        .en    (state_r == CLEAR),
        .cnt_x (clr_x_s),
        .cnt_y (clr_y_s),
        .nxt_x (clr_nx_s),
        .nxt_y (clr_ny_s),
        .last  (clr_last_s)
    );

    // Midpoint step and choice of the octant point that will be shown in the next cycle.
    always_comb begin
        rad_ext_s = $signed({3'b000, rad_r});
        oy_n_s    = oy_r + 10'sd1;
        if (crit_r <= 10'sd0) begin
            ox_n_s   = ox_r;
            crit_n_s = crit_r + (oy_n_s <<< 1) + 10'sd1;
        end else begin
            ox_n_s   = ox_r - 10'sd1;
            crit_n_s = crit_r + ((oy_n_s - ox_n_s) <<< 1) + 10'sd1;
        end
        cont_s = (oy_n_s <= ox_n_s);

        case (state_r)
            INIT:    begin sel_k_s = 3'd0;       sel_ox_s = rad_ext_s; sel_oy_s = 10'sd0;  end
            OCT:     begin sel_k_s = k_r + 3'd1; sel_ox_s = ox_r;      sel_oy_s = oy_r;    end
            UPD:     begin sel_k_s = 3'd0;       sel_ox_s = ox_n_s;    sel_oy_s = oy_n_s;  end
            default: begin sel_k_s = 3'd0;       sel_ox_s = ox_r;      sel_oy_s = oy_r;    end
        endcase
        pix_s = oct_point(sel_k_s, $signed({2'b00, cx_r}), $signed({3'b000, cy_r}),
                          sel_ox_s, sel_oy_s, SW_C, SH_C);
    end

    // Sequencer FSM; every output is registered for the cycle the next state is shown.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            k_r       <= 3'd0;
            cx_r      <= {X_W{1'b0}};
            cy_r      <= {Y_W{1'b0}};
            rad_r     <= 7'd0;
            col_r     <= {COL_W{1'b0}};
            ox_r      <= 10'sd0;
            oy_r      <= 10'sd0;
            crit_r    <= 10'sd0;
            x_r       <= {X_W{1'b0}};
            y_r       <= {Y_W{1'b0}};
            col_out_r <= {COL_W{1'b0}};
            plot_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        cx_r      <= centre_x;
                        cy_r      <= centre_y;
                        rad_r     <= radius;
                        col_r     <= colour;
                        x_r       <= {X_W{1'b0}};
                        y_r       <= {Y_W{1'b0}};
                        col_out_r <= CLEAR_COLOUR;
                        plot_r    <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= CLEAR;
                    end else begin
                        plot_r    <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_last_s) begin
                        plot_r  <= 1'b0;
                        state_r <= INIT;
                    end else begin
                        x_r       <= clr_nx_s;
                        y_r       <= clr_ny_s;
                        col_out_r <= CLEAR_COLOUR;
                        plot_r    <= 1'b1;
                    end
                end
                INIT: begin
                    ox_r      <= rad_ext_s;
                    oy_r      <= 10'sd0;
                    crit_r    <= 10'sd1 - rad_ext_s;
                    k_r       <= 3'd0;
                    x_r       <= pix_s.px[X_W-1:0];
                    y_r       <= pix_s.py[Y_W-1:0];
                    col_out_r <= col_r;
                    plot_r    <= pix_s.vis;
                    state_r   <= OCT;
                end
                OCT: begin
                    if (k_r == 3'd7) begin
                        plot_r  <= 1'b0;
                        state_r <= UPD;
                    end else begin
                        k_r       <= k_r + 3'd1;
                        x_r       <= pix_s.px[X_W-1:0];
                        y_r       <= pix_s.py[Y_W-1:0];
                        col_out_r <= col_r;
                        plot_r    <= pix_s.vis;
                    end
                end
                UPD: begin
                    ox_r   <= ox_n_s;
                    oy_r   <= oy_n_s;
                    crit_r <= crit_n_s;
                    if (cont_s) begin
                        k_r       <= 3'd0;
                        x_r       <= pix_s.px[X_W-1:0];
                        y_r       <= pix_s.py[Y_W-1:0];
                        col_out_r <= col_r;
                        plot_r    <= pix_s.vis;
                        state_r   <= OCT;
                    end else begin
                        plot_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    plot_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    plot_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign x          = x_r;
    assign y          = y_r;
    assign colour_out = col_out_r;
    assign plot       = plot_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_circle_draw_ctrl.sv
// Bench for circle_draw_ctrl: a queue of expected per-cycle outputs built from a plain integer model.
module tb_circle_draw_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [6:0] radius;
    logic [2:0] colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;

    typedef struct {
        bit plot;
        int x;
        int y;
        int col;
        bit busy;
        bit done;
    } rec_t;

    rec_t exp_q[$];
    rec_t run_q[$];
    rec_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   chk_en = 1'b0;
    bit   fresh  = 1'b0;

    always #5 clock = ~clock;

    circle_draw_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .colour     (colour),
        .x          (x),
        .y          (y),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    // Model: the whole cycle-by-cycle output list of one run, starting the cycle after accept.
    task automatic model_run(input int cx, input int cy, input int r, input int col);
        int sx[8]   = '{1, 1, -1, -1, -1, -1, 1, 1};
        int sy[8]   = '{1, 1, 1, 1, -1, -1, -1, -1};
        bit swp[8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
        int ox, oy, d, px, py;
        rec_t q;
        run_q.delete();
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                run_q.push_back('{1'b1, xx, yy, 0, 1'b1, 1'b0});
        run_q.push_back('{1'b0, 0, 0, 0, 1'b1, 1'b0});
        ox = r; oy = 0; d = 1 - r;
        while (oy <= ox) begin
            for (int k = 0; k < 8; k++) begin
                px = cx + sx[k] * (swp[k] ? oy : ox);
                py = cy + sy[k] * (swp[k] ? ox : oy);
                q = '{(px >= 0 && px < 160 && py >= 0 && py < 120), px, py, col, 1'b1, 1'b0};
                run_q.push_back(q);
            end
            run_q.push_back('{1'b0, 0, 0, 0, 1'b1, 1'b0});
            oy = oy + 1;
            if (d <= 0) d = d + 2 * oy + 1;
            else begin
                ox = ox - 1;
                d = d + 2 * (oy - ox) + 1;
            end
        end
        run_q.push_back('{1'b0, 0, 0, 0, 1'b1, 1'b1});
    endtask

    task automatic append_run();
        foreach (run_q[i]) exp_q.push_back(run_q[i]);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic wait_q_le(input int n, input int budget);
        int i = 0;
        while (exp_q.size() > n && i < budget) begin
            @(negedge clock);
            i++;
        end
        check("wait_budget", (exp_q.size() > n) ? 1 : 0, 0);
    endtask

    task automatic rand_inputs();
        centre_x = 8'($urandom);
        centre_y = 7'($urandom);
        radius   = 7'($urandom);
        colour   = 3'($urandom);
    endtask

    // Cycle compare: every cycle, DUT outputs against the head of the expected queue (or idle).
    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            cyc++;
            checks++;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                if (plot !== cur.plot || busy !== cur.busy || done !== cur.done ||
                    (cur.plot && (int'(x) != cur.x || int'(y) != cur.y || int'(colour_out) != cur.col))) begin
                    errors++;
                    $display("FAIL cycle %0d: got plot=%0b x=%0d y=%0d col=%0d busy=%0b done=%0b expected plot=%0b x=%0d y=%0d col=%0d busy=%0b done=%0b",
                             cyc, plot, x, y, colour_out, busy, done,
                             cur.plot, cur.x, cur.y, cur.col, cur.busy, cur.done);
                end
            end else begin
                if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                    (fresh && (x !== 8'd0 || y !== 7'd0 || colour_out !== 3'd0))) begin
                    errors++;
                    $display("FAIL idle cycle %0d: got plot=%0b busy=%0b done=%0b x=%0d y=%0d col=%0d expected all 0",
                             cyc, plot, busy, done, x, y, colour_out);
                end
            end
        end
    end

    initial begin
        int r1x[16] = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
        int r1y[16] = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};
        int lc, ld, col_b, col_c, cx, cy, rr, cc;

        reset = 1'b1; start = 1'b0;
        centre_x = 8'd0; centre_y = 7'd0; radius = 7'd0; colour = 3'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0; fresh = 1'b1; chk_en = 1'b1;
        repeat (4) @(negedge clock);

        // Hand-computed anchors for the model itself.
        model_run(80, 60, 1, 3);
        check("model_r1_len", run_q.size(), 19220);
        for (int k = 0; k < 16; k++) begin
            check("model_r1_x", run_q[19201 + k + (k / 8)].x, r1x[k]);
            check("model_r1_y", run_q[19201 + k + (k / 8)].y, r1y[k]);
        end
        check("model_clear_wrap_y", run_q[160].y, 1);
        check("model_clear_last_x", run_q[19199].x, 159);
        model_run(80, 60, 5, 1);
        check("model_r5_len", run_q.size(), 19238);
        model_run(2, 2, 5, 1);
        check("model_r5_clip_len", run_q.size(), 19238);
        check("model_r5_clip_k2", int'(run_q[19203].plot), 0);
        model_run(80, 60, 0, 5);
        check("model_r0_len", run_q.size(), 19211);
        check("model_r0_done", int'(run_q[19210].done), 1);

        // Run A: radius 0, single start pulse, inputs scrambled after accept.
        centre_x = 8'd80; centre_y = 7'd60; radius = 7'd0; colour = 3'd5;
        append_run();
        fresh = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        rand_inputs();
        wait_q_le(0, 20000);
        repeat (3) @(negedge clock);

        // Runs B and C: start held high throughout, second run starts right after done.
        col_b = int'($urandom_range(0, 7));
        col_c = int'($urandom_range(0, 7));
        centre_x = 8'd80; centre_y = 7'd60; radius = 7'd1; colour = 3'(col_b);
        model_run(80, 60, 1, col_b);
        append_run();
        exp_q.push_back('{1'b0, 0, 0, 0, 1'b0, 1'b0});
        model_run(2, 2, 5, col_c);
        lc = run_q.size();
        append_run();
        start = 1'b1;
        repeat (50) @(negedge clock);
        rand_inputs();
        wait_q_le(lc + 3, 20000);
        centre_x = 8'd2; centre_y = 7'd2; radius = 7'd5; colour = 3'(col_c);
        wait_q_le(lc - 5, 100);
        rand_inputs();
        start = 1'b0;
        wait_q_le(0, 20000);
        repeat (3) @(negedge clock);

        // Run D: random circle, reset lands in the first octant sweep.
        cx = int'($urandom_range(0, 255)); cy = int'($urandom_range(0, 127));
        rr = int'($urandom_range(1, 127)); cc = int'($urandom_range(0, 7));
        centre_x = 8'(cx); centre_y = 7'(cy); radius = 7'(rr); colour = 3'(cc);
        model_run(cx, cy, rr, cc);
        ld = run_q.size();
        append_run();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_q_le(ld - 19203, 20000);
        reset = 1'b1; exp_q.delete(); fresh = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Run E: restart begins at (0,0) again, then reset mid-clear.
        cx = int'($urandom_range(0, 159)); cy = int'($urandom_range(0, 119));
        rr = int'($urandom_range(0, 127)); cc = int'($urandom_range(0, 7));
        centre_x = 8'(cx); centre_y = 7'(cy); radius = 7'(rr); colour = 3'(cc);
        model_run(cx, cy, rr, cc);
        append_run();
        fresh = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (30) @(negedge clock);
        reset = 1'b1; exp_q.delete(); fresh = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/circle_draw_ctrl.md
Name: circle_draw_ctrl

Overview:
Drawing sequencer that drives the write port of the 160x120, 3-bit-colour `vga_adapter` framebuffer (x, y, colour, plot).
- On a start request it first clears the whole screen to a background colour.
- It then rasterises one circle with the integer midpoint algorithm, emitting at most one pixel write per clock.
- It sits between the switch/key front end and `vga_adapter`, and replaces the free-running raster counter as the pixel source.

Parameters:
- SCREEN_W, 160, horizontal pixel count; valid x is 0..SCREEN_W-1.
- SCREEN_H, 120, vertical pixel count; valid y is 0..SCREEN_H-1.
- CLEAR_COLOUR, 3'b000, colour written during the clear pass.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a clear-then-draw; sampled only in IDLE.
- centre_x  in  8  circle centre x, latched at accept.
- centre_y  in  7  circle centre y, latched at accept.
- radius  in  7  circle radius 0..127, latched at accept.
- colour  in  3  circle colour, latched at accept.
- x  out  8  pixel x to vga_adapter.
- y  out  7  pixel y to vga_adapter.
- colour_out  out  3  pixel colour to vga_adapter.
- plot  out  1  write strobe; the pixel is written on a cycle where plot=1.
- busy  out  1  high from accept until DONE exits.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; x=0, y=0, colour_out=0, plot=0, busy=0, done=0.
- Reset mid-operation: abandon the drawing; plot=0 from the next cycle. The partially drawn frame stays as drawn.
- All outputs are registered. x, y, colour_out and plot change together.
- States: IDLE -> CLEAR -> INIT -> OCT -> UPD -> (OCT | DONE) -> IDLE.
- IDLE: plot=0, busy=0. When start=1 at edge t, latch the inputs and enter CLEAR; busy=1 from t+1. start is ignored in every other state.
- CLEAR:
  - Raster order, x fastest: (0,0), (1,0) .. (159,0), (0,1) .. (159,119).
  - plot=1 and colour_out=CLEAR_COLOUR every cycle.
  - Exactly 19200 cycles, the first at t+1. After (159,119), go to INIT.
- INIT (1 cycle, plot=0): ox=radius, oy=0, crit=1-radius.
- Arithmetic: ox, oy and crit are 10-bit signed. Pixel coordinates are computed as 10-bit signed sums of centre and offset.
- OCT: 8 cycles, octant index k=0..7. Pixel order:
  - k=0 (cx+ox, cy+oy), k=1 (cx+oy, cy+ox)
  - k=2 (cx-ox, cy+oy), k=3 (cx-oy, cy+ox)
  - k=4 (cx-ox, cy-oy), k=5 (cx-oy, cy-ox)
  - k=6 (cx+ox, cy-oy), k=7 (cx+oy, cy-ox)
- Clipping: a point with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H gets plot=0 for that cycle. The cycle is still consumed, so timing is data-independent.
- Duplicate points (e.g. ox==oy, or radius 0) are plotted again; no suppression.
- UPD (1 cycle, plot=0):
  - oy'=oy+1.
  - If crit<=0: crit'=crit+2*oy'+1.
  - Else: ox'=ox-1 and crit'=crit+2*(oy'-ox')+1.
  - If oy'<=ox', go to OCT with k=0; else go to DONE.
- DONE (1 cycle): done=1, plot=0, busy still 1. Next state IDLE, so start is accepted again 1 cycle after done.
- Total latency from accept edge t to the done cycle: 19200 + 1 + 9*N + 1 cycles, where N is the iteration count.

Decomposition:
- Shared package `vga_draw_pkg`:
  - Screen constants W=160, H=120.
  - Coordinate widths (X_W=8, Y_W=7, COL_W=3).
  - State enum {IDLE, CLEAR, INIT, OCT, UPD, DONE}.
- One natural sub-module: `screen_clear_counter`. It is the x/y raster counter with wrap at 159/119 and a last-pixel flag, enabled in CLEAR.
- The midpoint datapath and the FSM stay in `circle_draw_ctrl`.

Test Plan:
- Reset in IDLE, then start pulse -> cycles t+1..t+19200: plot=1, colour 0, first (0,0), last (159,119), row wrap after x=159.
- Centre (80,60), r=0, colour 5 -> after clear and INIT:
  - 8 plots, all (80,60), colour 5; then UPD; then done on cycle t+19211.
  - busy falls the cycle after done.
- Centre (80,60), r=1 -> first OCT:
  - (81,60), (80,61), (79,60), (80,61), (79,60), (80,59), (81,60), (80,59).
  - Second OCT: (81,61), (81,61), (79,61), (79,61), (79,59), (79,59), (81,59), (81,59).
  - done at t+19220.
- Centre (2,2), r=5 -> k=2 in iteration 1 (x=-3) has plot=0. Iteration count and done cycle are identical to centre (80,60), r=5.
- Start held high continuously plus a new start mid-CLEAR -> no restart. Latched inputs are unchanged; a second run begins exactly 1 cycle after the done pulse.
- Reset asserted during OCT -> plot=0, busy=0 on the next cycle, state IDLE. A subsequent start restarts the clear at (0,0).
